mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multicycle MIPS core. It accepts the controller's memory requests (`MemWrite`, `MemMode`, address, write data) and services them against an internal word-organised RAM after a configurable number of wait states. It returns read data as a word, sign-extended byte or zero-extended byte, and signals completion with a one-cycle `ready` pulse. It sits between the datapath's address/IorD mux and the instruction/memory-data registers.

## Interface
- `ADDR_WIDTH`, default 10: significant byte-address bits. RAM depth is 2^(ADDR_WIDTH-2) 32-bit words. Higher address bits are ignored, so addresses wrap.
- `WAIT_CYCLES`, default 2: wait-state count, 0..15, inserted before each access.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: reset is asynchronous and active-high.
- `req` input, 1 bit: request valid, sampled only while idle.
- `MemWrite` input, 1 bit: 1 = write, 0 = read.
- `MemMode` input, 2 bits: 00 word, 01 signed byte, 10 unsigned byte, 11 treated as word.
- `addr` input, 32 bits: byte address.
- `wdata` input, 32 bits: write data. Byte writes use `wdata[7:0]`.
- `rdata` output, 32 bits: read result, registered.
- `ready` output, 1 bit: one-cycle completion pulse.
- `busy` output, 1 bit: a request is in progress.
- `err` output, 1 bit: misaligned word access flag, valid only with `ready`.

## Operation
- States: IDLE, WAIT, ACCESS.
- **IDLE**
  - On a rising edge with `req`=1, latch `addr`, `MemWrite`, `MemMode` and `wdata`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES`>0, otherwise go to ACCESS.
- **WAIT**: decrement the counter each edge. Go to ACCESS on the edge where the counter reaches 1.
- **ACCESS**: perform the access on the edge leaving this state, set `ready`=1 for the next cycle, and return to IDLE.
- **Byte lanes** are big-endian. `addr[1:0]`=00 selects bits 31:24, 01 selects 23:16, 10 selects 15:8, 11 selects 7:0.
- **Word read**: `rdata` = RAM[addr[ADDR_WIDTH-1:2]].
- **Signed byte read**: `rdata` = selected byte sign-extended from bit 7.
- **Unsigned byte read**: `rdata` = selected byte zero-extended.
- **Word write**: the full word is replaced.
- **Byte write**: only the addressed lane is replaced; the other three lanes are unchanged.
- **Misaligned word access** (mode 00/11 with `addr[1:0]`≠00):
  - No RAM write.
  - `rdata` set to 0.
  - `err`=1 together with `ready`.
- `err` is 0 on every other completion.
- `rdata` holds its value until the next read completes. Writes leave `rdata` unchanged.
- `req` is ignored while `busy`=1. No queueing.

## Timing
- **Reset values**: state IDLE, `rdata`=0, `ready`=0, `busy`=0, `err`=0, counter 0. RAM contents are not reset.
- **Latency**: for a request accepted at edge E, `ready` is high during the cycle after edge E+WAIT_CYCLES+1, for exactly one cycle. With `WAIT_CYCLES`=0, `ready` follows the cycle after edge E+1.
- **busy**: high from the cycle after acceptance until the `ready` cycle. It is low during the `ready` cycle.
- **Back-to-back requests**: in the `ready` cycle the block is IDLE, so a `req` present then is accepted at the next edge.
- **Write visibility**: the write commits at the ACCESS edge. A read accepted afterwards returns the new data.
- **Reset mid-operation**: asynchronously abort to IDLE and clear all outputs. A write that has not reached its ACCESS edge is not committed.
- **Address wrap**: `addr` = 2^ADDR_WIDTH + 4 accesses the same word as `addr` = 4.

## Test plan
- **Word round trip**: write 0x12345678 to addr 0x10, then read word at 0x10 → `rdata`=0x12345678, `err`=0, `ready` exactly WAIT_CYCLES+1 cycles after each accept edge.
- **Byte read extension**: after the word above is stored with 0x80 in one lane (0x12_80_5678 at 0x10):
  - signed byte at 0x11 → 0xFFFFFF80;
  - unsigned byte at 0x11 → 0x00000080;
  - unsigned byte at 0x13 → 0x00000078.
- **Byte write lane**: write 0xAB with `MemMode`=01 to addr 0x12 over 0x12345678, then read word → 0x1234AB78.
- **Misaligned word**: word read at 0x11 → `rdata`=0, `err`=1 with `ready`. Word write at 0x13 leaves the word at 0x10 unchanged.
- **Busy and back-to-back**: pulse `req` again during WAIT → ignored, with a single `ready` pulse. Hold `req` high through the `ready` cycle → second request accepted with no idle gap.
- **Reset mid-write**: assert `reset` during WAIT of a write of 0xDEADBEEF to 0x20 → outputs 0 immediately; a subsequent read of 0x20 returns the prior value.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS core: word and byte
// accesses to an internal big-endian RAM after a fixed number of wait states.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [1:0]  MemMode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            mode_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;

  logic [31:0] ram [DEPTH];

  logic                  word_m;
  logic                  misal;
  logic                  wr_en;
  logic [ADDR_WIDTH-3:0] widx;
  logic [31:0]           word;
  logic [7:0]            byte_sel;
  logic [31:0]           rd_d;
  logic [31:0]           wr_d;
  logic                  unused_addr;

  // Address bits above ADDR_WIDTH are ignored, so accesses wrap.
  assign unused_addr = ^addr[31:ADDR_WIDTH];

  assign word_m = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign misal  = word_m && (addr_q[1:0] != 2'b00);
  assign widx   = addr_q[ADDR_WIDTH-1:2];
  assign word   = ram[widx];
  assign wr_en  = (state_q == ACCESS) && we_q && !misal;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byte_sel = word[7:0];
    unique case (addr_q[1:0])
      2'b00: byte_sel = word[31:24];
      2'b01: byte_sel = word[23:16];
      2'b10: byte_sel = word[15:8];
      2'b11: byte_sel = word[7:0];
    endcase
  end

  always_comb begin
    rd_d = word;
    if (misal) begin
      rd_d = 32'h0;
    end else if (mode_q == 2'b01) begin
      rd_d = {{24{byte_sel[7]}}, byte_sel};
    end else if (mode_q == 2'b10) begin
      rd_d = {24'h0, byte_sel};
    end
  end

  always_comb begin
    wr_d = wdata_q;
    if (!word_m) begin
      wr_d = word;
      unique case (addr_q[1:0])
        2'b00: wr_d[31:24] = wdata_q[7:0];
        2'b01: wr_d[23:16] = wdata_q[7:0];
        2'b10: wr_d[15:8]  = wdata_q[7:0];
        2'b11: wr_d[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[widx] <= wr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      mode_q  <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr[ADDR_WIDTH-1:0];
            we_q    <= MemWrite;
            mode_q  <= MemMode;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          err_q   <= misal;
          if (!we_q || misal) begin
            rdata_q <= rd_d;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
